// File: rtl/dmx_tx_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : dmx_tx_sequencer_if
// Purpose  : Bundles the frame configuration, slot-store read port, UART byte
//            handshake and status signals of the DMX512 transmit sequencer.
// Ports    : master - sequencer side (drives slot reads, bytes, status)
//            slave  - environment side (slot store, UART, configuration)
// Revision : 1.0 - initial release
// ============================================================================
interface dmx_tx_sequencer_if;
  // configuration
  logic        enable;
  logic [9:0]  num_slots;
  logic [7:0]  start_code;
  logic [1:0]  refresh_sel;
  // slot store read port
  logic        slot_rd;
  logic [8:0]  slot_addr;
  logic [7:0]  slot_data;
  // UART byte handshake
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        uart_busy;
  // line control and status
  logic        break_out;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_count;

  modport master (
    input  enable, num_slots, start_code, refresh_sel,
    input  slot_data, byte_ready, uart_busy,
    output slot_rd, slot_addr, byte_valid, byte_data,
    output break_out, busy, frame_done, frame_count
  );

  modport slave (
    output enable, num_slots, start_code, refresh_sel,
    output slot_data, byte_ready, uart_busy,
    input  slot_rd, slot_addr, byte_valid, byte_data,
    input  break_out, busy, frame_done, frame_count
  );
endinterface
`default_nettype wire

// File: rtl/dmx_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dmx_tx_sequencer
// Purpose  : DMX512 frame controller. Drives BREAK and MAB on the line, then
//            streams the start code and N slot bytes from the slot store to
//            the byte UART, and paces frames to the selected refresh rate.
// Ports    : clk    - system clock, rising edge
//            rst_n  - asynchronous active-low reset
//            dmx    - configuration, slot read port, UART handshake, status
// Revision : 1.0 - initial release
// ============================================================================
module dmx_tx_sequencer #(
  parameter int CLK_FREQ = 12000000,
  parameter int BREAK_US = 176,
  parameter int MAB_US   = 12
) (
  input logic                clk,
  input logic                rst_n,
  dmx_tx_sequencer_if.master dmx
);

  localparam int CYC_PER_US = CLK_FREQ / 1000000;
  localparam int BREAK_CYC  = CYC_PER_US * BREAK_US;
  localparam int MAB_CYC    = CYC_PER_US * MAB_US;
  localparam int TMR_W      = $clog2((BREAK_CYC > MAB_CYC) ? BREAK_CYC : MAB_CYC) + 1;

  localparam logic [TMR_W-1:0] BREAK_LOAD = TMR_W'(BREAK_CYC - 1);
  localparam logic [TMR_W-1:0] MAB_LOAD   = TMR_W'(MAB_CYC - 1);

  // Frame periods in clock cycles, truncated.
  localparam logic [18:0] PER_44 = 19'(CLK_FREQ / 44);
  localparam logic [18:0] PER_30 = 19'(CLK_FREQ / 30);
  localparam logic [18:0] PER_40 = 19'(CLK_FREQ / 40);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_BREAK     = 4'd1,
    S_MAB       = 4'd2,
    S_START     = 4'd3,
    S_FETCH     = 4'd4,
    S_WAIT_DATA = 4'd5,
    S_SEND      = 4'd6,
    S_DRAIN     = 4'd7,
    S_GAP       = 4'd8
  } state_t;

  state_t            state_q;
  logic [TMR_W-1:0]  tmr_q;
  logic [18:0]       per_cnt_q;
  logic [18:0]       per_len_q;
  logic [9:0]        n_q;
  logic [7:0]        sc_q;
  logic [9:0]        idx_q;
  logic              break_out_q;
  logic              byte_valid_q;
  logic [7:0]        byte_data_q;
  logic              slot_rd_q;
  logic [8:0]        slot_addr_q;
  logic              busy_q;
  logic [15:0]       fcnt_q;

  logic [9:0]        n_d;
  logic [18:0]       per_len_d;
  logic [9:0]        idx_nxt_d;
  logic              accept_d;
  logic              last_d;
  logic              per_done_d;
  logic              go_break_d;

  always_comb begin
    // Out-of-range slot counts (0 or above 512) mean a full universe.
    n_d = ((dmx.num_slots == 10'd0) || (dmx.num_slots > 10'd512)) ? 10'd512 : dmx.num_slots;

    per_len_d = 19'd0;
    case (dmx.refresh_sel)
      2'b01:   per_len_d = PER_44;
      2'b10:   per_len_d = PER_30;
      2'b11:   per_len_d = PER_40;
      default: per_len_d = 19'd0;
    endcase

    idx_nxt_d  = idx_q + 10'd1;
    accept_d   = byte_valid_q && dmx.byte_ready;
    last_d     = !(idx_nxt_d < n_q);
    per_done_d = (per_cnt_q >= per_len_q);

    // BREAK can be entered from IDLE or at the end of the inter-frame gap.
    go_break_d = ((state_q == S_IDLE) && dmx.enable && !dmx.uart_busy) ||
                 ((state_q == S_GAP)  && dmx.enable && per_done_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      tmr_q        <= '0;
      per_cnt_q    <= '0;
      per_len_q    <= '0;
      n_q          <= 10'd512;
      sc_q         <= 8'h00;
      idx_q        <= '0;
      break_out_q  <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= 8'h00;
      slot_rd_q    <= 1'b0;
      slot_addr_q  <= '0;
      busy_q       <= 1'b0;
      fcnt_q       <= '0;
    end else begin
      slot_rd_q <= 1'b0;
      if (per_cnt_q != '1) begin
        per_cnt_q <= per_cnt_q + 19'd1;
      end

      case (state_q)
        S_IDLE: ;  // leaving IDLE is handled by go_break_d below

        S_BREAK: begin
          if (tmr_q == '0) begin
            state_q     <= S_MAB;
            tmr_q       <= MAB_LOAD;
            break_out_q <= 1'b0;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end

        S_MAB: begin
          if (tmr_q == '0) begin
            state_q      <= S_START;
            byte_valid_q <= 1'b1;
            byte_data_q  <= sc_q;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end

        S_START: begin
          if (accept_d) begin
            state_q      <= S_FETCH;
            byte_valid_q <= 1'b0;
            slot_rd_q    <= 1'b1;
            slot_addr_q  <= idx_q[8:0];
          end
        end

        // The read strobe is already on the port during FETCH; the store
        // returns data one cycle later, captured at the end of WAIT_DATA.
        S_FETCH: state_q <= S_WAIT_DATA;

        S_WAIT_DATA: begin
          state_q      <= S_SEND;
          byte_valid_q <= 1'b1;
          byte_data_q  <= dmx.slot_data;
        end

        S_SEND: begin
          if (accept_d) begin
            byte_valid_q <= 1'b0;
            if (!last_d) begin
              state_q     <= S_FETCH;
              idx_q       <= idx_nxt_d;
              slot_rd_q   <= 1'b1;
              slot_addr_q <= idx_nxt_d[8:0];
            end else begin
              state_q <= S_DRAIN;
              fcnt_q  <= fcnt_q + 16'd1;
            end
          end
        end

        S_DRAIN: begin
          if (!dmx.uart_busy) begin
            state_q <= S_GAP;
          end
        end

        S_GAP: begin
          if (per_done_d && !dmx.enable) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q      <= S_IDLE;
          busy_q       <= 1'b0;
          break_out_q  <= 1'b0;
          byte_valid_q <= 1'b0;
        end
      endcase

      // Frame start: latch configuration and restart the period counter.
      if (go_break_d) begin
        state_q     <= S_BREAK;
        tmr_q       <= BREAK_LOAD;
        per_cnt_q   <= '0;
        per_len_q   <= per_len_d;
        n_q         <= n_d;
        sc_q        <= dmx.start_code;
        idx_q       <= '0;
        break_out_q <= 1'b1;
        busy_q      <= 1'b1;
      end
    end
  end

  assign dmx.break_out   = break_out_q;
  assign dmx.byte_valid  = byte_valid_q;
  assign dmx.byte_data   = byte_data_q;
  assign dmx.slot_rd     = slot_rd_q;
  assign dmx.slot_addr   = slot_addr_q;
  assign dmx.busy        = busy_q;
  assign dmx.frame_count = fcnt_q;
  // Must pulse in the accept cycle itself, so it follows byte_ready directly.
  assign dmx.frame_done  = (state_q == S_SEND) && accept_d && last_d;

endmodule
`default_nettype wire

// File: tb/tb_dmx_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmx_tx_sequencer
// Purpose  : Self-checking bench for dmx_tx_sequencer. Stimulus pushes the
//            expected byte/address stream of each frame into queues; a
//            monitor pops and compares on every accept and slot read.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmx_tx_sequencer;
  localparam int CLK_FREQ  = 1000000;
  localparam int BREAK_US  = 176;
  localparam int MAB_US    = 12;
  localparam int BREAK_CYC = (CLK_FREQ / 1000000) * BREAK_US;
  localparam int MAB_CYC   = (CLK_FREQ / 1000000) * MAB_US;
  localparam int PER_40    = CLK_FREQ / 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmx_tx_sequencer_if u_if ();

  dmx_tx_sequencer #(
    .CLK_FREQ(CLK_FREQ),
    .BREAK_US(BREAK_US),
    .MAB_US  (MAB_US)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .dmx  (u_if)
  );

  // Slot store model: data valid one cycle after the read strobe.
  logic [7:0] mem [512];
  always @(posedge clk) if (u_if.slot_rd) u_if.slot_data <= mem[u_if.slot_addr];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [7:0] exp_byte_q [$];
  bit         exp_last_q [$];
  int         exp_addr_q [$];

  task automatic push_frame(input int ns, input logic [7:0] sc);
    int n;
    n = (ns == 0 || ns > 512) ? 512 : ns;
    exp_byte_q.push_back(sc);
    exp_last_q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      exp_byte_q.push_back(mem[i]);
      exp_last_q.push_back(i == n - 1);
      exp_addr_q.push_back(i);
    end
  endtask

  // ---------------- monitor ----------------
  int          fd_cnt = 0, brk_starts = 0, rd_cnt = 0, acc_cnt = 0;
  int unsigned brk_start_cyc = 0, prev_brk_start_cyc = 0;
  int          brk_len = 0, mab_len = 0;
  bit          in_mab = 0, prev_brk = 0, prev_stall = 0;
  logic [7:0]  prev_data = 8'h00;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        brk_len = 0; in_mab = 0; prev_brk = 0; prev_stall = 0;
      end else begin
        if (u_if.break_out) begin
          if (!prev_brk) begin
            brk_starts++;
            prev_brk_start_cyc = brk_start_cyc;
            brk_start_cyc = cyc;
          end
          brk_len++;
        end else if (prev_brk) begin
          chk("break_len", brk_len, BREAK_CYC);
          brk_len = 0; in_mab = 1; mab_len = 1;
        end else if (in_mab) begin
          if (u_if.byte_valid) begin
            chk("mab_len", mab_len, MAB_CYC);
            in_mab = 0;
          end else mab_len++;
        end
        prev_brk = u_if.break_out;

        if (prev_stall) chk("hold_stable", {u_if.byte_valid, u_if.byte_data}, {1'b1, prev_data});
        prev_stall = u_if.byte_valid && !u_if.byte_ready;
        prev_data  = u_if.byte_data;

        if (u_if.slot_rd) begin
          rd_cnt++;
          chk("slot_rd_expected", exp_addr_q.size() > 0, 1);
          if (exp_addr_q.size() > 0) chk("slot_addr", u_if.slot_addr, exp_addr_q.pop_front());
        end

        if (u_if.byte_valid && u_if.byte_ready) begin
          acc_cnt++;
          chk("byte_expected", exp_byte_q.size() > 0, 1);
          if (exp_byte_q.size() > 0) begin
            chk("byte_data", u_if.byte_data, exp_byte_q.pop_front());
            chk("frame_done_at_last", u_if.frame_done, exp_last_q.pop_front());
          end
        end else if (u_if.frame_done) begin
          chk("frame_done_stray", u_if.frame_done, 0);
        end
        if (u_if.frame_done) fd_cnt++;
      end
    end
  end

  // ---------------- random byte_ready ----------------
  bit rnd_ready = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_ready) u_if.byte_ready = ($urandom_range(0, 9) < 7);
    end
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_fd(input int base, input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin tick(1); ok = (fd_cnt > base); end
  endtask

  task automatic wait_idle(input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin tick(1); ok = !u_if.busy; end
  endtask

  task automatic wait_brk(input int target, input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin tick(1); ok = (brk_starts >= target); end
  endtask

  task automatic wait_rd(input int addr, input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      tick(1);
      ok = u_if.slot_rd && (u_if.slot_addr == 9'(addr));
    end
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_break_out"},   u_if.break_out, 0);
    chk({tag, "_byte_valid"},  u_if.byte_valid, 0);
    chk({tag, "_byte_data"},   u_if.byte_data, 0);
    chk({tag, "_slot_rd"},     u_if.slot_rd, 0);
    chk({tag, "_slot_addr"},   u_if.slot_addr, 0);
    chk({tag, "_busy"},        u_if.busy, 0);
    chk({tag, "_frame_done"},  u_if.frame_done, 0);
    chk({tag, "_frame_count"}, u_if.frame_count, 0);
  endtask

  int exp_fc = 0;

  // One enabled frame, enable released after it completes.
  task automatic run_frame(input int ns, input logic [7:0] sc);
    int fd0, rd0, acc0, n;
    bit ok;
    n = (ns == 0 || ns > 512) ? 512 : ns;
    u_if.num_slots = 10'(ns); u_if.start_code = sc; u_if.refresh_sel = 2'b00;
    push_frame(ns, sc);
    fd0 = fd_cnt; rd0 = rd_cnt; acc0 = acc_cnt;
    u_if.enable = 1'b1;
    wait_fd(fd0, 6000, ok);
    chk("frame_done_seen", ok, 1);
    u_if.enable = 1'b0;
    wait_idle(400, ok);
    chk("return_idle", ok, 1);
    chk("slot_reads", rd_cnt - rd0, n);
    chk("bytes_accepted", acc_cnt - acc0, n + 1);
    chk("bytes_left", exp_byte_q.size(), 0);
    exp_fc++;
    chk("frame_count", u_if.frame_count, exp_fc);
  endtask

  // ---------------- main ----------------
  initial begin
    bit ok;
    int fd0, rd0, b0;
    int unsigned fall;

    u_if.enable = 1'b0; u_if.num_slots = 10'd4; u_if.start_code = 8'h00;
    u_if.refresh_sel = 2'b00; u_if.byte_ready = 1'b1; u_if.uart_busy = 1'b0;
    rand_mem();
    tick(3);
    check_reset_values("por");
    rst_n = 1'b1;
    tick(2);

    // 40 Hz pacing with two back-to-back frames, then reset inside the second BREAK.
    u_if.num_slots = 10'd4; u_if.start_code = 8'h00; u_if.refresh_sel = 2'b11;
    push_frame(4, 8'h00);
    push_frame(4, 8'h00);
    b0 = brk_starts;
    u_if.enable = 1'b1;
    wait_brk(b0 + 2, PER_40 + 2000, ok);
    chk("second_break_seen", ok, 1);
    chk("frame_period", brk_start_cyc - prev_brk_start_cyc, PER_40 + 1);
    chk("frame_count_first", u_if.frame_count, 1);
    tick(30);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    u_if.enable = 1'b0;
    exp_byte_q.delete(); exp_last_q.delete(); exp_addr_q.delete();
    exp_fc = 0;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Full universe via num_slots=0 with random back-pressure.
    rand_mem();
    rnd_ready = 1;
    run_frame(0, 8'($urandom));

    // byte_ready held low for 5 cycles on slot 2.
    rnd_ready = 0; u_if.byte_ready = 1'b1;
    rand_mem();
    u_if.num_slots = 10'd4; u_if.start_code = 8'h00; u_if.refresh_sel = 2'b00;
    push_frame(4, 8'h00);
    fd0 = fd_cnt; rd0 = rd_cnt;
    u_if.enable = 1'b1;
    wait_rd(2, 2000, ok);
    chk("slot2_read_seen", ok, 1);
    u_if.byte_ready = 1'b0;
    tick(2);
    chk("slot2_offered", u_if.byte_valid, 1);
    tick(5);
    u_if.byte_ready = 1'b1;
    wait_fd(fd0, 100, ok);
    chk("stall_frame_done", ok, 1);
    u_if.enable = 1'b0;
    wait_idle(100, ok);
    chk("stall_idle", ok, 1);
    chk("stall_reads", rd_cnt - rd0, 4);
    exp_fc++;

    // enable dropped during slot 1: frame completes, no new BREAK.
    rand_mem();
    push_frame(4, 8'h00);
    fd0 = fd_cnt;
    u_if.enable = 1'b1;
    wait_rd(1, 2000, ok);
    chk("slot1_read_seen", ok, 1);
    u_if.enable = 1'b0;
    wait_idle(200, ok);
    chk("disable_idle", ok, 1);
    b0 = brk_starts;
    tick(50);
    chk("disable_one_done", fd_cnt - fd0, 1);
    chk("disable_no_break", brk_starts - b0, 0);
    chk("disable_busy_low", u_if.busy, 0);
    exp_fc++;
    chk("disable_frame_count", u_if.frame_count, exp_fc);

    // Back-to-back with UART draining 20 cycles after the last accept.
    rand_mem();
    u_if.num_slots = 10'd3; u_if.start_code = 8'h55; u_if.refresh_sel = 2'b00;
    push_frame(3, 8'h55);
    push_frame(3, 8'h55);
    fd0 = fd_cnt; b0 = brk_starts;
    u_if.enable = 1'b1;
    wait_fd(fd0, 2000, ok);
    chk("drain_first_done", ok, 1);
    u_if.uart_busy = 1'b1;
    tick(20);
    chk("drain_holds_break", brk_starts - b0, 1);
    u_if.uart_busy = 1'b0;
    fall = cyc;
    wait_brk(b0 + 2, 50, ok);
    chk("drain_break_seen", ok, 1);
    // DRAIN exits on the first idle sample, one GAP cycle, then BREAK.
    chk("break_after_busy", brk_start_cyc - fall, 2);
    u_if.enable = 1'b0;
    wait_fd(fd0 + 1, 2000, ok);
    chk("drain_second_done", ok, 1);
    wait_idle(100, ok);
    chk("drain_idle", ok, 1);
    exp_fc += 2;
    chk("drain_frame_count", u_if.frame_count, exp_fc);

    // Randomized frames, including an oversize slot count.
    rnd_ready = 1;
    for (int k = 0; k < 4; k++) begin
      rand_mem();
      run_frame((k == 2) ? int'($urandom_range(513, 1023)) : int'($urandom_range(1, 40)),
                8'($urandom));
    end
    rnd_ready = 0;

    chk("queues_empty", exp_byte_q.size() + exp_addr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
